rf_op_sequencer: RTL



---
 rtl/rf_pkg.sv | 29 ++
 rtl/rf_op_sequencer_if.sv | 43 ++++
 rtl/rf_alu.sv | 37 +++
 rtl/rf_op_sequencer.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
`default_nettype none
// rf_pkg: sizes, op codes and sequencer state encoding, shared with the register file.
// Rev 1.0
package rf_pkg;

  localparam int DATA_W   = 64;
  localparam int ADDR_W   = 8;
  localparam int NUM_REGS = 64;

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_AND  = 3'd2,
    OP_OR   = 3'd3,
    OP_XOR  = 3'd4,
    OP_SLL  = 3'd5,
    OP_SRL  = 3'd6,
    OP_PASS = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_CAPTURE = 2'd2,
    S_WRITE   = 2'd3
  } state_e;

endpackage : rf_pkg
`default_nettype wire

// File: rtl/rf_op_sequencer_if.sv
`default_nettype none
// rf_op_sequencer_if: command channel, register-file ports and completion status.
// Rev 1.0
interface rf_op_sequencer_if #(
  parameter int DATA_W = rf_pkg::DATA_W,
  parameter int ADDR_W = rf_pkg::ADDR_W
);

  logic              cmd_valid;
  logic              cmd_ready;
  logic [2:0]        cmd_op;
  logic [ADDR_W-1:0] cmd_rs1;
  logic [ADDR_W-1:0] cmd_rs2;
  logic [ADDR_W-1:0] cmd_rd;

  logic [ADDR_W-1:0] read_reg1;
  logic [ADDR_W-1:0] read_reg2;
  logic [DATA_W-1:0] read_data1;
  logic [DATA_W-1:0] read_data2;
  logic [ADDR_W-1:0] write_reg;
  logic [DATA_W-1:0] write_data;
  logic              reg_write;
  logic              En;

  logic              done;
  logic              err;
  logic [DATA_W-1:0] result;

  // master is the sequencer; slave is the control path plus register file.
  modport master (
    input  cmd_valid, cmd_op, cmd_rs1, cmd_rs2, cmd_rd, read_data1, read_data2,
    output cmd_ready, read_reg1, read_reg2, write_reg, write_data, reg_write, En,
           done, err, result
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_rs1, cmd_rs2, cmd_rd, read_data1, read_data2,
    input  cmd_ready, read_reg1, read_reg2, write_reg, write_data, reg_write, En,
           done, err, result
  );

endinterface : rf_op_sequencer_if
`default_nettype wire

// File: rtl/rf_alu.sv
`default_nettype none
// rf_alu: combinational (op, a, b) -> y; arithmetic wraps, shifts use the low bits of b.
// Rev 1.0
module rf_alu
  import rf_pkg::*;
#(
  parameter int DATA_W = rf_pkg::DATA_W
) (
  input  op_e               op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] y
);

  localparam int SH_W = $clog2(DATA_W);

  logic [SH_W-1:0] shamt;

  assign shamt = b[SH_W-1:0];

  always_comb begin
    y = a;
    case (op)
      OP_ADD:  y = a + b;
      OP_SUB:  y = a - b;
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_SLL:  y = a << shamt;
      OP_SRL:  y = a >> shamt;
      OP_PASS: y = a;
      default: y = a;
    endcase
  end

endmodule : rf_alu
`default_nettype wire

// File: rtl/rf_op_sequencer.sv
`default_nettype none
// rf_op_sequencer: accepts one command, reads rs1/rs2, computes and writes rd; 4 cycles per op.
// Rev 1.0
module rf_op_sequencer #(
  parameter int DATA_W   = rf_pkg::DATA_W,
  parameter int ADDR_W   = rf_pkg::ADDR_W,
  parameter int NUM_REGS = rf_pkg::NUM_REGS
) (
  input  logic              Clk,
  input  logic              Rst_n,
  rf_op_sequencer_if.master bus
);

  import rf_pkg::*;

  state_e            state;
  op_e               cur_op;
  logic [ADDR_W-1:0] cur_rd;
  logic              rs1_bad;
  logic              rs2_bad;
  logic              rd_bad;

  logic              cmd_ready;
  logic [ADDR_W-1:0] read_reg1;
  logic [ADDR_W-1:0] read_reg2;
  logic [ADDR_W-1:0] write_reg;
  logic [DATA_W-1:0] write_data;
  logic              reg_write;
  logic              wr_en;
  logic              done;
  logic              err;
  logic [DATA_W-1:0] result;

  logic [DATA_W-1:0] opnd_a;
  logic [DATA_W-1:0] opnd_b;
  logic [DATA_W-1:0] alu_y;
  logic              accept;

  function automatic logic out_of_range(input logic [ADDR_W-1:0] addr);
    return int'(addr) >= NUM_REGS;
  endfunction

  assign accept = (state == S_IDLE) && bus.cmd_valid && cmd_ready;

  // Out-of-range sources read as zero regardless of what the file returns.
  assign opnd_a = rs1_bad ? '0 : bus.read_data1;
  assign opnd_b = rs2_bad ? '0 : bus.read_data2;

  rf_alu #(
    .DATA_W (DATA_W)
  ) u_alu (
    .op (cur_op),
    .a  (opnd_a),
    .b  (opnd_b),
    .y  (alu_y)
  );

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state      <= S_IDLE;
      cur_op     <= OP_ADD;
      cur_rd     <= '0;
      rs1_bad    <= 1'b0;
      rs2_bad    <= 1'b0;
      rd_bad     <= 1'b0;
      cmd_ready  <= 1'b0;
      read_reg1  <= '0;
      read_reg2  <= '0;
      write_reg  <= '0;
      write_data <= '0;
      reg_write  <= 1'b0;
      wr_en      <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      result     <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        S_IDLE: begin
          cmd_ready <= 1'b1;
          if (accept) begin
            cur_op    <= op_e'(bus.cmd_op);
            cur_rd    <= bus.cmd_rd;
            rs1_bad   <= out_of_range(bus.cmd_rs1);
            rs2_bad   <= out_of_range(bus.cmd_rs2);
            rd_bad    <= out_of_range(bus.cmd_rd);
            read_reg1 <= bus.cmd_rs1;
            read_reg2 <= bus.cmd_rs2;
            cmd_ready <= 1'b0;
            state     <= S_ISSUE;
          end
        end

        S_ISSUE: begin
          state <= S_CAPTURE;
        end

        S_CAPTURE: begin
          write_data <= alu_y;
          write_reg  <= cur_rd;
          reg_write  <= !rd_bad;
          wr_en      <= !rd_bad;
          state      <= S_WRITE;
        end

        S_WRITE: begin
          // Write lands on this edge; status and result surface together with the return to IDLE.
          reg_write  <= 1'b0;
          wr_en      <= 1'b0;
          write_reg  <= '0;
          write_data <= '0;
          read_reg1  <= '0;
          read_reg2  <= '0;
          result     <= write_data;
          done       <= 1'b1;
          err        <= rs1_bad | rs2_bad | rd_bad;
          cmd_ready  <= 1'b1;
          state      <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.cmd_ready  = cmd_ready;
  assign bus.read_reg1  = read_reg1;
  assign bus.read_reg2  = read_reg2;
  assign bus.write_reg  = write_reg;
  assign bus.write_data = write_data;
  assign bus.reg_write  = reg_write;
  assign bus.En         = wr_en;
  assign bus.done       = done;
  assign bus.err        = err;
  assign bus.result     = result;

endmodule : rf_op_sequencer
`default_nettype wire
